// File: rtl/spi_shifter_if.sv
// Bus between an SPI clock generator/controller and the spi_shifter data path.
// The master modport belongs to the controller; the slave modport belongs to the shifter.
interface spi_shifter_if #(
    parameter int DATA_W = 32
) ();
    localparam int LEN_W = $clog2(DATA_W);

    logic              go;
    logic [LEN_W-1:0]  char_len;
    logic              lsb;
    logic              tx_negedge;
    logic              rx_negedge;
    logic              pos_edge;
    logic              neg_edge;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              busy;
    logic              last_clk;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              done;

    modport master (
        output go, char_len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, tx_data, miso,
        input  busy, last_clk, mosi, rx_data, done
    );

    modport slave (
        input  go, char_len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, tx_data, miso,
        output busy, last_clk, mosi, rx_data, done
    );
endinterface

// File: rtl/spi_shifter.sv
// SPI character shifter: serialises tx_data onto mosi and assembles miso into rx_data,
// stepping on SCLK edge strobes supplied by an external clock generator.
module spi_shifter #(
    parameter int DATA_W = 32
) (
    input  logic         clk_in,
    input  logic         rst,
    spi_shifter_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int LEN_W = IDX_W + 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  tx_idx_q, tx_idx_d;
    logic [LEN_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              lsb_q, lsb_d;
    logic              tx_neg_q, tx_neg_d;
    logic              rx_neg_q, rx_neg_d;

    logic [LEN_W-1:0]  go_len;
    logic [LEN_W-1:0]  go_first;
    logic [LEN_W-1:0]  tx_pos;
    logic              tx_stb;
    logic              rx_stb;

    // char_len of zero encodes a full DATA_W character, hence the extra length bit.
    assign go_len   = (bus.char_len == '0) ? LEN_W'(DATA_W) : {1'b0, bus.char_len};
    assign go_first = bus.lsb ? '0 : go_len - LEN_W'(1);
    assign tx_pos   = lsb_q ? tx_idx_q : len_q - tx_idx_q - LEN_W'(1);
    assign tx_stb   = tx_neg_q ? bus.neg_edge : bus.pos_edge;
    assign rx_stb   = rx_neg_q ? bus.neg_edge : bus.pos_edge;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_data_d = rx_data_q;
        len_d     = len_q;
        tx_idx_d  = tx_idx_q;
        rx_cnt_d  = rx_cnt_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        lsb_d     = lsb_q;
        tx_neg_d  = tx_neg_q;
        rx_neg_d  = rx_neg_q;

        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d   = XFER;
                    tx_sr_d   = bus.tx_data;
                    rx_data_d = '0;
                    len_d     = go_len;
                    tx_idx_d  = LEN_W'(1);
                    rx_cnt_d  = '0;
                    mosi_d    = bus.tx_data[go_first[IDX_W-1:0]];
                    lsb_d     = bus.lsb;
                    tx_neg_d  = bus.tx_negedge;
                    rx_neg_d  = bus.rx_negedge;
                end
            end
            XFER: begin
                if (tx_stb && (tx_idx_q < len_q)) begin
                    mosi_d   = tx_sr_q[tx_pos[IDX_W-1:0]];
                    tx_idx_d = tx_idx_q + LEN_W'(1);
                end
                if (rx_stb) begin
                    if (lsb_q) begin
                        rx_data_d[rx_cnt_q[IDX_W-1:0]] = bus.miso;
                    end else begin
                        rx_data_d = {rx_data_q[DATA_W-2:0], bus.miso};
                    end
                    rx_cnt_d = rx_cnt_q + LEN_W'(1);
                    if (rx_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_data_q <= '0;
            len_q     <= '0;
            tx_idx_q  <= '0;
            rx_cnt_q  <= '0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_neg_q  <= 1'b0;
            rx_neg_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_data_q <= rx_data_d;
            len_q     <= len_d;
            tx_idx_q  <= tx_idx_d;
            rx_cnt_q  <= rx_cnt_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            lsb_q     <= lsb_d;
            tx_neg_q  <= tx_neg_d;
            rx_neg_q  <= rx_neg_d;
        end
    end

    assign bus.busy     = (state_q == XFER);
    assign bus.last_clk = (state_q == XFER) && (rx_cnt_q == len_q - LEN_W'(1));
    assign bus.mosi     = mosi_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: SCLK strobes are generated by hand, mosi is optionally
// looped back to miso, and each result is compared against hand-computed constants.
module tb_spi_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        loop = 1'b1;
    logic        miso_fix = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [31:0] seq;
    logic [31:0] lc_mask;
    logic        m_s, lc_s;

    spi_shifter_if #(.DATA_W(32)) sif ();

    spi_shifter #(.DATA_W(32)) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (sif.slave)
    );

    always #5 clk = ~clk;

    assign sif.miso = loop ? sif.mosi : miso_fix;

    always @(negedge clk) if (sif.done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] data, input int clen, input logic l,
                         input logic txn, input logic rxn);
        sif.tx_data    = data;
        sif.char_len   = 5'(clen);
        sif.lsb        = l;
        sif.tx_negedge = txn;
        sif.rx_negedge = rxn;
        sif.go         = 1'b1;
        @(negedge clk);
        sif.go         = 1'b0;
    endtask

    task automatic pulse_pos();
        sif.pos_edge = 1'b1;
        @(negedge clk);
        sif.pos_edge = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_neg();
        sif.neg_edge = 1'b1;
        @(negedge clk);
        sif.neg_edge = 1'b0;
        @(negedge clk);
    endtask

    // One SCLK cycle; mosi and last_clk are sampled as they stand just before the rising strobe.
    task automatic sclk_cycle(output logic m, output logic lc);
        m  = sif.mosi;
        lc = sif.last_clk;
        pulse_pos();
        pulse_neg();
    endtask

    initial begin
        sif.go = 1'b0; sif.char_len = '0; sif.lsb = 1'b0; sif.tx_negedge = 1'b1;
        sif.rx_negedge = 1'b0; sif.pos_edge = 1'b0; sif.neg_edge = 1'b0; sif.tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", sif.busy, 1'b0);
        check("rst_mosi", sif.mosi, 1'b0);
        check("rst_rx", sif.rx_data, 32'h0);
        check("rst_done", sif.done, 1'b0);
        check("rst_last", sif.last_clk, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, 8 bits MSB first, loopback.
        start(32'hA5, 8, 1'b0, 1'b1, 1'b0);
        check("m0_busy", sif.busy, 1'b1);
        check("m0_first", sif.mosi, 1'b1);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            sclk_cycle(m_s, lc_s);
            seq = {seq[30:0], m_s};
        end
        check("m0_seq", seq, 32'hA5);
        check("m0_rx", sif.rx_data, 32'h0000_00A5);
        check("m0_done", done_cnt, 1);
        check("m0_idle", sif.busy, 1'b0);

        // Idle strobes must not disturb rx_data or mosi.
        loop = 1'b0; miso_fix = 1'b0;
        pulse_pos(); pulse_neg();
        check("idle_rx", sif.rx_data, 32'h0000_00A5);
        check("idle_mosi", sif.mosi, 1'b1);
        loop = 1'b1;

        // Full 32 bits, LSB first.
        start(32'h8000_0001, 0, 1'b1, 1'b1, 1'b0);
        seq = '0; lc_mask = '0;
        for (int i = 0; i < 32; i++) begin
            sclk_cycle(m_s, lc_s);
            seq[i] = m_s;
            lc_mask[i] = lc_s;
        end
        check("l32_seq", seq, 32'h8000_0001);
        check("l32_rx", sif.rx_data, 32'h8000_0001);
        check("l32_last", lc_mask, 32'h8000_0000);
        check("l32_done", done_cnt, 2);

        // 4 bits, miso tied high, captured on neg_edge only.
        loop = 1'b0; miso_fix = 1'b1;
        start(32'h0, 4, 1'b0, 1'b0, 1'b1);
        pulse_pos();
        check("neg_pos_ign", sif.rx_data, 32'h0);
        pulse_neg();
        check("neg_first", sif.rx_data, 32'h1);
        for (int i = 0; i < 3; i++) sclk_cycle(m_s, lc_s);
        check("neg_rx", sif.rx_data, 32'h0000_000F);
        check("neg_done", done_cnt, 3);
        loop = 1'b1;

        // go mid-transfer is ignored.
        start(32'h5A, 8, 1'b0, 1'b1, 1'b0);
        seq = '0;
        for (int i = 0; i < 3; i++) begin
            sclk_cycle(m_s, lc_s);
            seq = {seq[30:0], m_s};
        end
        sif.tx_data = 32'hFF; sif.go = 1'b1;
        @(negedge clk);
        sif.go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sclk_cycle(m_s, lc_s);
            seq = {seq[30:0], m_s};
        end
        check("mid_busy", sif.busy, 1'b1);
        check("mid_early", done_cnt, 3);
        sclk_cycle(m_s, lc_s);
        seq = {seq[30:0], m_s};
        check("mid_seq", seq, 32'h5A);
        check("mid_rx", sif.rx_data, 32'h0000_005A);
        check("mid_done", done_cnt, 4);

        // Reset after 3 of 8 bits aborts without done.
        start(32'hC3, 8, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) sclk_cycle(m_s, lc_s);
        rst = 1'b1;
        @(negedge clk);
        check("ab_busy", sif.busy, 1'b0);
        check("ab_mosi", sif.mosi, 1'b0);
        check("ab_rx", sif.rx_data, 32'h0);
        check("ab_last", sif.last_clk, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ab_nodone", done_cnt, 4);
        start(32'h3C, 8, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) sclk_cycle(m_s, lc_s);
        check("ab_rx2", sif.rx_data, 32'h0000_003C);
        check("ab_done2", done_cnt, 5);

        // Back-to-back: second go on the done cycle.
        start(32'h96, 8, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) sclk_cycle(m_s, lc_s);
        sif.pos_edge = 1'b1;
        @(negedge clk);
        sif.pos_edge = 1'b0;
        check("b2b_done", sif.done, 1'b1);
        check("b2b_rx1", sif.rx_data, 32'h0000_0096);
        sif.tx_data = 32'h69; sif.go = 1'b1;
        @(negedge clk);
        sif.go = 1'b0;
        check("b2b_busy", sif.busy, 1'b1);
        check("b2b_first", sif.mosi, 1'b0);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            sclk_cycle(m_s, lc_s);
            seq = {seq[30:0], m_s};
        end
        check("b2b_seq", seq, 32'h69);
        check("b2b_rx2", sif.rx_data, 32'h0000_0069);
        check("b2b_cnt", done_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_shifter.md
SPI_SHIFTER -- requirements
Module: spi_shifter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the maximum character length and the width of the data ports.
REQ-002 Clock/reset SHALL be: one clock; reset is asynchronous and active-high (clk_in, rst).
REQ-003 clk_in  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 go  input  1  single-cycle start request.
REQ-006 char_len  input  $clog2(DATA_W)  bits per character; value 0 means DATA_W.
REQ-007 lsb  input  1  1 = LSB first, 0 = MSB first.
REQ-008 tx_negedge  input  1  1 = drive mosi on neg_edge strobes, 0 = on pos_edge strobes.
REQ-009 rx_negedge  input  1  1 = sample miso on neg_edge strobes, 0 = on pos_edge strobes.
REQ-010 pos_edge, neg_edge  input  1 each  one-cycle SCLK edge strobes from the SPI clock generator.
REQ-011 tx_data  input  DATA_W  character to transmit; bits [len-1:0] used.
REQ-012 miso  input  1  serial receive data.
REQ-013 busy  output  1  transfer in progress; drives the clock generator enable.
REQ-014 last_clk  output  1  final SCLK cycle of the character; drives the clock generator last_clk.
REQ-015 mosi  output  1  serial transmit data.
REQ-016 rx_data  output  DATA_W  received character, right-aligned.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 Effective length len SHALL be char_len, or DATA_W when char_len is 0.
REQ-019 FSM SHALL have two states: IDLE and XFER.
REQ-020 IDLE + go: next cycle state = XFER, busy = 1. Also: tx_data latched into tx shift register, rx_data cleared to 0, tx_idx = 1, rx_cnt = 0.
REQ-021 IDLE + go: mosi SHALL also load the first bit, which is tx_data[len-1] if lsb = 0, else tx_data[0].
REQ-022 lsb, char_len, tx_negedge and rx_negedge SHALL be latched at go and held for the whole transfer.
REQ-023 tx strobe = latched tx_negedge ? neg_edge : pos_edge.
REQ-024 rx strobe = latched rx_negedge ? neg_edge : pos_edge.
REQ-025 Strobes SHALL be acted on only in XFER.
REQ-026 On a tx strobe in XFER with tx_idx < len, mosi SHALL take the next bit in the selected order and tx_idx SHALL increment. With tx_idx = len, mosi SHALL hold.
REQ-027 On an rx strobe in XFER, miso SHALL be captured and rx_cnt SHALL increment.
REQ-028 MSB-first capture SHALL be rx_data = {rx_data[DATA_W-2:0], miso}.
REQ-029 LSB-first capture SHALL be rx_data[rx_cnt] = miso.
REQ-030 After len captures, rx_data[len-1:0] SHALL hold the received character and the upper bits SHALL be 0.
REQ-031 tx and rx strobes in the same cycle SHALL both take effect.
REQ-032 last_clk SHALL be 1 exactly when state = XFER and rx_cnt = len-1 (combinational).
REQ-033 The capture that makes rx_cnt = len SHALL transition to IDLE next cycle: busy = 0 and done = 1 for exactly one cycle.
REQ-034 rx_data SHALL then hold until the next go.
REQ-035 go while in XFER SHALL be ignored.
REQ-036 go on the cycle done is high SHALL start a new transfer.
REQ-037 In IDLE, mosi SHALL hold its last value.
REQ-038 In IDLE, pos_edge/neg_edge strobes SHALL have no effect.

Reset
REQ-039 While rst = 1, state SHALL be IDLE and busy, last_clk, mosi, done = 0.
REQ-040 While rst = 1, rx_data, tx shift register, tx_idx and rx_cnt SHALL be 0.
REQ-041 rst asserted during XFER SHALL abort the transfer immediately with no done pulse.
REQ-042 After rst deasserts, the first go SHALL behave per REQ-020 and REQ-021.

Verification
REQ-043 Mode 0 (tx_negedge = 1, rx_negedge = 0), len 8, MSB first:
- stimulus: tx_data = 0xA5, miso looped to mosi;
- required: mosi sequence 1,0,1,0,0,1,0,1; rx_data = 0x000000A5; one done pulse; 8 pos_edge captures.
REQ-044 char_len = 0, LSB first:
- stimulus: tx_data = 0x80000001, miso looped to mosi;
- required: 32 bits sent bit0 first; rx_data = 0x80000001; last_clk high during exactly the 32nd SCLK cycle.
REQ-045 len 4, miso tied 1, rx_negedge = 1:
- required: rx_data = 0x0000000F after 4 neg_edge captures; pos_edge strobes ignored by rx.
REQ-046 go pulsed mid-transfer:
- required: ignored; tx_idx and rx_cnt unaffected; a single done pulse.
REQ-047 rst asserted after 3 of 8 bits:
- required: busy = 0, mosi = 0, rx_data = 0, no done pulse; a subsequent go with tx_data = 0x3C completes with rx_data = 0x3C in loopback.
REQ-048 Back-to-back transfers:
- stimulus: go on the done cycle;
- required: second transfer starts with no idle gap; both characters received correctly.
